// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI memory responder:
// FSM state encoding, default commands and address width.
package qspi_pkg;

    localparam int QSPI_AW = 24;

    localparam logic [7:0] QSPI_CMD_READ  = 8'hEB;
    localparam logic [7:0] QSPI_CMD_WRITE = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } qspi_state_e;

endpackage

// File: rtl/qspi_sync_edge.sv
// Two-flop synchroniser for an asynchronous bit plus
// single-cycle rise/fall pulses on the synchronised level.
module qspi_sync_edge
    import qspi_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] s_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q <= '0;
        end else begin
            s_q <= {s_q[1:0], d_i};
        end
    end

    assign rise_o = s_q[1] & ~s_q[2];
    assign fall_o = ~s_q[1] & s_q[2];

endmodule

// File: rtl/qspi_mem_responder.sv
// QSPI memory responder: device end of the ExoTiny QSPI bus.
// Decodes quad read/write and serves bytes from a backing memory port.
module qspi_mem_responder
    import qspi_pkg::*;
#(
    parameter int         MEM_AW       = QSPI_AW,
    parameter int         DUMMY_CYCLES = 4,
    parameter logic [7:0] CMD_READ     = QSPI_CMD_READ,
    parameter logic [7:0] CMD_WRITE    = QSPI_CMD_WRITE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_n_i,
    input  logic              sck_i,
    input  logic [3:0]        sd_i,
    output logic [3:0]        sd_o,
    output logic [3:0]        sd_oen_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    logic cs_rise, cs_fall, sck_rise, sck_fall;
    logic act, rise, fall, rack, avail, rd_start;
    logic [7:0]  rbyte, cmd;
    logic [23:0] adr;

    qspi_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [19:0] sh_q, sh_d;
    logic        rd_q, rd_d, nib_q, nib_d;
    logic [3:0]  hi_q, hi_d, lo_q, lo_d;
    logic [7:0]  buf_q, buf_d, wd_q, wd_d;
    logic        bvld_q, bvld_d, pend_q, pend_d, drop_q, drop_d;
    logic [MEM_AW-1:0] addr_q, addr_d, maddr_q, maddr_d;
    logic        req_q, req_d, we_q, we_d, err_q, err_d;
    logic [3:0]  sdo_q, sdo_d, oen_q, oen_d;
    logic [3:0]  sd_m_q, sd_s_q;

    qspi_sync_edge u_cs_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (cs_n_i),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    qspi_sync_edge u_sck_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (sck_i),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // sck edges only count once a transfer has been opened by cs_n falling
    assign act   = (state_q != ST_IDLE);
    assign rise  = sck_rise & act;
    assign fall  = sck_fall & act;
    assign rack  = req_q & mem_ack_i & ~we_q & ~drop_q;
    assign avail = bvld_q | rack;
    assign rbyte = bvld_q ? buf_q : mem_rdata_i;
    assign cmd   = {sh_q[6:0], sd_s_q[0]};
    assign adr   = {sh_q, sd_s_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        rd_d     = rd_q;
        nib_d    = nib_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        buf_d    = buf_q;
        bvld_d   = bvld_q;
        pend_d   = pend_q;
        drop_d   = drop_q;
        addr_d   = addr_q;
        maddr_d  = maddr_q;
        req_d    = req_q;
        we_d     = we_q;
        wd_d     = wd_q;
        err_d    = err_q;
        sdo_d    = sdo_q;
        oen_d    = oen_q;
        rd_start = 1'b0;

        if (req_q && mem_ack_i) begin
            req_d  = 1'b0;
            drop_d = 1'b0;
            if (rack) begin
                buf_d  = mem_rdata_i;
                bvld_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_CMD: begin
                if (rise) begin
                    sh_d  = {sh_q[18:0], sd_s_q[0]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d = '0;
                        rd_d  = (cmd == CMD_READ);
                        if (cmd == CMD_READ || cmd == CMD_WRITE) begin
                            state_d = ST_ADDR;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (rise) begin
                    sh_d  = {sh_q[15:0], sd_s_q};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd5) begin
                        cnt_d  = '0;
                        nib_d  = 1'b0;
                        addr_d = adr[MEM_AW-1:0];
                        if (rd_q) begin
                            rd_start = 1'b1;
                            state_d  = (DUMMY_CYCLES == 0) ? ST_RDATA : ST_DUMMY;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
            end
            ST_DUMMY: begin
                if (rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(DUMMY_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_RDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (fall) begin
                    oen_d = 4'hF;
                    nib_d = ~nib_q;
                    if (nib_q) begin
                        sdo_d = lo_q;
                    end else if (avail) begin
                        sdo_d    = rbyte[7:4];
                        lo_d     = rbyte[3:0];
                        bvld_d   = 1'b0;
                        rd_start = 1'b1;
                    end else begin
                        sdo_d = '0;
                        lo_d  = '0;
                        err_d = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (rise) begin
                    nib_d = ~nib_q;
                    if (!nib_q) begin
                        hi_d = sd_s_q;
                    end else if (req_q) begin
                        err_d = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        maddr_d = addr_q;
                        wd_d    = {hi_q, sd_s_q};
                        addr_d  = addr_q + MEM_AW'(1);
                    end
                end
            end
            default: begin
            end
        endcase

        // reads wait here while a previous request is still in flight
        if (pend_q || rd_start) begin
            if (!req_q) begin
                req_d   = 1'b1;
                we_d    = 1'b0;
                maddr_d = addr_d;
                addr_d  = addr_d + MEM_AW'(1);
                pend_d  = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end

        if (cs_rise) begin
            state_d = ST_IDLE;
            oen_d   = '0;
            sdo_d   = '0;
            pend_d  = 1'b0;
            bvld_d  = 1'b0;
            nib_d   = 1'b0;
            if (!req_q) begin
                req_d = 1'b0;
            end
            if (req_q && !mem_ack_i && !we_q) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            rd_q    <= 1'b0;
            nib_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            buf_q   <= '0;
            bvld_q  <= 1'b0;
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            maddr_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            sdo_q   <= '0;
            oen_q   <= '0;
            sd_m_q  <= '0;
            sd_s_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            nib_q   <= nib_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            buf_q   <= buf_d;
            bvld_q  <= bvld_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            maddr_q <= maddr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            sdo_q   <= sdo_d;
            oen_q   <= oen_d;
            sd_m_q  <= sd_i;
            sd_s_q  <= sd_m_q;
        end
    end

    assign sd_o        = sdo_q;
    assign sd_oen_o    = oen_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = maddr_q;
    assign mem_wdata_o = wd_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench for qspi_mem_responder: a QSPI initiator with sck = clk/4
// and a backing-memory model with programmable ack latency.
module tb_qspi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cs_n_i = 1'b1;
    logic        sck_i = 1'b0;
    logic [3:0]  sd_i = 4'h0;
    logic [3:0]  sd_o, sd_oen_o;
    logic        mem_req_o, mem_we_o;
    logic [23:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i = 8'h00;
    logic        mem_ack_i = 1'b0;
    logic        err_o;

    int total = 0;
    int bad = 0;

    qspi_mem_responder dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cs_n_i      (cs_n_i),
        .sck_i       (sck_i),
        .sd_i        (sd_i),
        .sd_o        (sd_o),
        .sd_oen_o    (sd_oen_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [int unsigned];
    int unsigned rd_log[$];
    int unsigned wr_a[$];
    logic [7:0]  wr_d[$];
    int mlat = 1;
    int wcnt = 0;

    always @(posedge clk) begin
        mem_ack_i <= 1'b0;
        if (mem_req_o && !mem_ack_i) begin
            if (wcnt >= mlat) begin
                mem_ack_i <= 1'b1;
                wcnt <= 0;
                if (mem_we_o) begin
                    mem[mem_addr_o] = mem_wdata_o;
                    wr_a.push_back(mem_addr_o);
                    wr_d.push_back(mem_wdata_o);
                end else begin
                    rd_log.push_back(mem_addr_o);
                    mem_rdata_i <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : 8'h00;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else if (!mem_req_o) begin
            wcnt <= 0;
        end
    end

    logic mon_en = 1'b0;
    int   mon_req = 0;
    int   mon_oen = 0;

    always @(posedge clk) begin
        if (mon_en) begin
            if (mem_req_o) mon_req <= mon_req + 1;
            if (sd_oen_o != 4'h0) mon_oen <= mon_oen + 1;
        end
    end

    logic [3:0] rnib [8];
    logic [3:0] roen [8];
    logic [3:0] oen_pre;

    // one sck period: drive sd while low, rise, then sample just before the fall
    task automatic sck_cyc(input logic [3:0] dout, output logic [3:0] din);
        sd_i = dout;
        repeat (2) @(posedge clk);
        #1 sck_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 din = sd_o;
        sck_i = 1'b0;
    endtask

    task automatic xfer_start(input logic [7:0] c);
        logic [3:0] d;
        cs_n_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 7; i >= 0; i--) sck_cyc({3'b000, c[i]}, d);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [3:0] d;
        for (int i = 5; i >= 0; i--) sck_cyc(a[i*4 +: 4], d);
    endtask

    task automatic cs_end();
        repeat (2) @(posedge clk);
        #1 cs_n_i = 1'b1;
        sd_i = 4'h0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [23:0] a, input int nd);
        logic [3:0] d;
        xfer_start(8'hEB);
        send_addr(a);
        for (int i = 0; i < 4; i++) sck_cyc(4'h0, d);
        oen_pre = sd_oen_o;
        for (int i = 0; i < nd; i++) begin
            sck_cyc(4'h0, d);
            rnib[i] = d;
            roen[i] = sd_oen_o;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (sd_o !== 4'h0) begin bad++; $display("FAIL rst_sd_o got=%h want=0", sd_o); end
        total++; if (sd_oen_o !== 4'h0) begin bad++; $display("FAIL rst_oen got=%h want=0", sd_oen_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req_o); end
        total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_we_o); end
        total++; if (mem_addr_o !== 24'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_addr_o); end
        total++; if (mem_wdata_o !== 8'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", mem_wdata_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_o); end
    endtask

    task automatic test_read();
        logic [3:0] exp [4];
        exp = '{4'hA, 4'h5, 4'h3, 4'hC};
        mem[32'h100] = 8'hA5;
        mem[32'h101] = 8'h3C;
        rd_log.delete();
        do_read(24'h000100, 4);
        total++; if (oen_pre !== 4'h0) begin bad++; $display("FAIL rd_oen_dummy got=%h want=0", oen_pre); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rnib[i] !== exp[i]) begin bad++; $display("FAIL rd_nib%0d got=%h want=%h", i, rnib[i], exp[i]); end
            total++;
            if (roen[i] !== 4'hF) begin bad++; $display("FAIL rd_oen%0d got=%h want=f", i, roen[i]); end
        end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", err_o); end
        total++;
        if (rd_log.size() < 1 || rd_log[0] !== 32'h100) begin
            bad++; $display("FAIL rd_first_addr got=%0d entries want=0x100", rd_log.size());
        end
        cs_end();
        total++; if (sd_oen_o !== 4'h0) begin bad++; $display("FAIL rd_oen_idle got=%h want=0", sd_oen_o); end
    endtask

    task automatic test_write();
        logic [3:0] d;
        wr_a.delete();
        wr_d.delete();
        xfer_start(8'h38);
        send_addr(24'h000020);
        sck_cyc(4'hD, d);
        sck_cyc(4'hE, d);
        sck_cyc(4'hA, d);
        sck_cyc(4'hD, d);
        cs_end();
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (wr_a.size() != 2) begin
            bad++; $display("FAIL wr_count got=%0d want=2", wr_a.size());
        end else begin
            if (wr_a[0] !== 32'h20 || wr_d[0] !== 8'hDE) begin
                bad++; $display("FAIL wr_byte0 got=%h:%h want=20:de", wr_a[0], wr_d[0]);
            end
            total++;
            if (wr_a[1] !== 32'h21 || wr_d[1] !== 8'hAD) begin
                bad++; $display("FAIL wr_byte1 got=%h:%h want=21:ad", wr_a[1], wr_d[1]);
            end
        end
        total++; if (sd_oen_o !== 4'h0) begin bad++; $display("FAIL wr_oen_idle got=%h want=0", sd_oen_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err_o); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp [4];
        exp = '{4'hE, 4'h7, 4'h4, 4'h2};
        mem[32'hFFFFFF] = 8'hE7;
        mem[32'h0] = 8'h42;
        rd_log.delete();
        do_read(24'hFFFFFF, 4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rnib[i] !== exp[i]) begin bad++; $display("FAIL wrap_nib%0d got=%h want=%h", i, rnib[i], exp[i]); end
        end
        total++;
        if (rd_log.size() < 2) begin
            bad++; $display("FAIL wrap_reads got=%0d want>=2", rd_log.size());
        end else if (rd_log[0] !== 32'hFFFFFF || rd_log[1] !== 32'h0) begin
            bad++; $display("FAIL wrap_addrs got=%h,%h want=ffffff,0", rd_log[0], rd_log[1]);
        end
        cs_end();
    endtask

    task automatic test_unknown();
        logic [3:0] d;
        logic [3:0] exp [4];
        exp = '{4'hC, 4'h3, 4'h9, 4'h6};
        mem[32'h300] = 8'hC3;
        mem[32'h301] = 8'h96;
        mon_req = 0;
        mon_oen = 0;
        mon_en = 1'b1;
        xfer_start(8'h9F);
        for (int i = 0; i < 16; i++) sck_cyc(4'h5, d);
        cs_end();
        mon_en = 1'b0;
        total++; if (mon_req != 0) begin bad++; $display("FAIL unk_req got=%0d want=0", mon_req); end
        total++; if (mon_oen != 0) begin bad++; $display("FAIL unk_oen got=%0d want=0", mon_oen); end
        do_read(24'h000300, 4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rnib[i] !== exp[i]) begin bad++; $display("FAIL unk_next_nib%0d got=%h want=%h", i, rnib[i], exp[i]); end
        end
        cs_end();
    endtask

    task automatic test_underrun();
        mem[32'h200] = 8'h5A;
        mlat = 20;
        do_read(24'h000200, 2);
        total++; if (rnib[0] !== 4'h0) begin bad++; $display("FAIL udr_nib got=%h want=0", rnib[0]); end
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL udr_err got=%b want=1", err_o); end
        cs_end();
        repeat (40) @(posedge clk);
        #1;
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL udr_err_sticky got=%b want=1", err_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL udr_req_done got=%b want=0", mem_req_o); end
        mlat = 1;
        do_reset();
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL udr_err_clr got=%b want=0", err_o); end
    endtask

    task automatic test_abort();
        logic [3:0] d;
        logic [3:0] exp [4];
        exp = '{4'hA, 4'h5, 4'h3, 4'hC};
        wr_a.delete();
        xfer_start(8'h38);
        send_addr(24'h000040);
        sck_cyc(4'h7, d);
        cs_end();
        repeat (10) @(posedge clk);
        #1;
        total++; if (wr_a.size() != 0) begin bad++; $display("FAIL abort_wr got=%0d want=0", wr_a.size()); end
        do_read(24'h000100, 1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({sd_o, sd_oen_o, mem_req_o, mem_we_o, err_o} !== 11'h0) begin
            bad++; $display("FAIL mid_rst_out got=%h/%h/%b/%b/%b want=0", sd_o, sd_oen_o, mem_req_o, mem_we_o, err_o);
        end
        total++;
        if (mem_addr_o !== 24'h0 || mem_wdata_o !== 8'h0) begin
            bad++; $display("FAIL mid_rst_bus got=%h/%h want=0", mem_addr_o, mem_wdata_o);
        end
        rst_i = 1'b0;
        cs_n_i = 1'b1;
        sd_i = 4'h0;
        repeat (8) @(posedge clk);
        #1;
        do_read(24'h000100, 4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rnib[i] !== exp[i]) begin bad++; $display("FAIL post_rst_nib%0d got=%h want=%h", i, rnib[i], exp[i]); end
        end
        cs_end();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_wrap();
        test_unknown();
        test_underrun();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Synthesizable QSPI memory responder: the device end of the ExoTiny QSPI memory bus (cs_n, sck, sd[3:0]).
- Emulates the external QSPI ROM/RAM on FPGA prototypes and in system benches; decodes the command and address streams and serves byte data from a backing memory port.
- Runs in the system clock domain and oversamples sck; clk_i must be at least 4x the sck frequency.

Parameters:
- MEM_AW, 24, backing-memory byte-address width (<=24); upper address bits are ignored.
- DUMMY_CYCLES, 4, sck cycles between the address phase and the read data phase for 0xEB.
- CMD_READ, 8'hEB, quad read command.
- CMD_WRITE, 8'h38, quad write command.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- cs_n_i  in  1  chip select, active low (asynchronous to clk_i)
- sck_i  in  1  serial clock (asynchronous)
- sd_i  in  4  serial data from initiator
- sd_o  out  4  serial data to initiator
- sd_oen_o  out  4  per-lane output enable, 1 = drive
- mem_req_o  out  1  backing-memory request, held until ack
- mem_we_o  out  1  1 = write
- mem_addr_o  out  MEM_AW  byte address
- mem_wdata_o  out  8  write byte
- mem_rdata_i  in  8  read byte, valid with ack
- mem_ack_i  in  1  one-cycle completion pulse
- err_o  out  1  sticky protocol error (underrun or overrun); cleared only by reset

Behaviour:
- Reset: one clock; reset is synchronous and active-high. Reset values: state IDLE, sd_o=0, sd_oen_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, err_o=0. Reset mid-transfer aborts the transfer immediately.
- Synchronisation: cs_n, sck and sd pass through 2-FF synchronisers.
- Edges: sck rise = sampled sck goes 0->1 (sample inputs); sck fall = 1->0 (update outputs). Edge detection is valid only while synced cs_n=0.
- Chip deselect: synced cs_n=1 in any state -> IDLE next cycle, sd_oen_o=0, incomplete nibble/byte discarded. An outstanding mem request still completes; read data is dropped, write data is committed.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE -> CMD when cs_n falls.
- CMD: 8 rises, single-lane on sd_i[0], MSB first.
  - CMD_READ or CMD_WRITE -> ADDR.
  - Any other command -> IGNORE (outputs stay disabled until cs_n rises).
- ADDR: 6 rises, quad, MSB nibble first; forms a 24-bit address.
  - Write -> WDATA.
  - Read -> DUMMY; the first mem read request is issued on the cycle after the 6th rise.
- DUMMY: counts DUMMY_CYCLES rises -> RDATA. DUMMY_CYCLES=0 goes straight to RDATA.
- RDATA:
  - sd_oen_o=4'hF from the first sck fall in RDATA.
  - Each fall drives one nibble, high nibble then low nibble.
  - The next byte (address+1) is prefetched into a one-byte buffer as soon as the high nibble is driven.
  - If the buffer is not filled by the fall that needs it: drive 4'h0, set err_o (underrun).
- WDATA:
  - Sd sampled on rises, high nibble first.
  - After the 2nd nibble: mem write request with current address, address increments.
  - A byte completing while a request is still outstanding is dropped and sets err_o (overrun).
- Address arithmetic: address increments by 1 per byte modulo 2^MEM_AW; all-ones wraps to 0.
- Mem handshake: req, we, addr and wdata are stable while req=1; req drops the cycle after ack. At most one request is outstanding.
- Latency: a byte read is ready on the same clock as ack; read data appears on sd_o 1 clk after the sck fall is detected (3 clk after the raw edge).

Decomposition:
- Package qspi_pkg: state enum (qspi_state_e), default command constants, address width constant.
- Sub-module qspi_sync_edge: 2-FF sync plus rise/fall pulse generation, instanced for sck and for cs_n.
- All other logic lives in qspi_mem_responder.

Test Plan:
- Quad read, DUMMY_CYCLES=4, memory {0x100:0xA5, 0x101:0x3C}, cmd 0xEB, addr 0x000100, 4 dummy, 4 data clocks -> sd_o nibbles 0xA, 0x5, 0x3, 0xC; sd_oen_o=0xF from the first data fall; err_o=0.
- Quad write, cmd 0x38, addr 0x000020, data 0xDE 0xAD -> mem writes (0x20, 0xDE), (0x21, 0xAD); cs_n high -> IDLE with sd_oen_o=0.
- Wrap, MEM_AW=24, read at 0xFFFFFF for 2 bytes -> mem reads 0xFFFFFF then 0x000000.
- Unknown command 0x9F followed by 16 clocks -> no mem_req_o, sd_oen_o stays 0; next 0xEB transaction works normally.
- Backing memory ack delayed 20 clks with sck at clk/4 -> sd_o=0 for the starved nibble and err_o=1 held until rst_i.
- Abort and reset: cs_n rises after 1 write nibble -> no mem write. rst_i asserted mid-read -> all outputs 0 on the next clk; a subsequent read returns correct data.
